// File: rtl/crt_clk_pkg.sv
// Shared types and ratio constants for the CRT clock-enable generator.
package crt_clk_pkg;

  // Decode width is wide enough for any practical CNT_W; users truncate.
  localparam int unsigned DEC_W = 8;

  typedef enum logic [1:0] {
    BPP_NONE = 2'b00,
    BPP_8    = 2'b01,
    BPP_16   = 2'b10,
    BPP_32   = 2'b11
  } bpp_e;

  localparam logic [DEC_W-1:0] RATIO_VGA_M1       = '0;
  localparam logic [DEC_W-1:0] RATIO_8BPP_M1_DEF  = 8'd3;
  localparam logic [DEC_W-1:0] RATIO_16BPP_M1_DEF = 8'd1;
  localparam logic [DEC_W-1:0] RATIO_32BPP_M1     = '0;

  function automatic logic [DEC_W-1:0] ratio_decode(
    input logic             vga_mode,
    input logic [1:0]       bpp,
    input logic [DEC_W-1:0] r8_m1,
    input logic [DEC_W-1:0] r16_m1
  );
    logic [DEC_W-1:0] r;
    if (vga_mode) begin
      r = RATIO_VGA_M1;
    end else begin
      case (bpp_e'(bpp))
        BPP_8:   r = r8_m1;
        BPP_16:  r = r16_m1;
        default: r = RATIO_32BPP_M1;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/crt_div_decode.sv
// Combinational requested-ratio selection: software override, then display mode.
module crt_div_decode
  import crt_clk_pkg::*;
#(
  parameter int unsigned CNT_W          = 3,
  parameter int unsigned RATIO_8BPP_M1  = 3,
  parameter int unsigned RATIO_16BPP_M1 = 1
) (
  input  logic             vga_mode,
  input  logic [1:0]       bpp,
  input  logic             div_ovr_en,
  input  logic [CNT_W-1:0] div_ovr_m1,
  output logic [CNT_W-1:0] req_m1
);

  localparam logic [DEC_W-1:0] R8_M1  = DEC_W'(RATIO_8BPP_M1);
  localparam logic [DEC_W-1:0] R16_M1 = DEC_W'(RATIO_16BPP_M1);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_m1 = CNT_W'(ratio_decode(vga_mode, bpp, R8_M1, R16_M1));
    if (div_ovr_en) begin
      req_m1 = div_ovr_m1;
    end
  end

endmodule

// File: rtl/crt_clk_en_gen.sv
// CRT clock-enable generator: one-cycle crt_clk pulse every cur_m1+1 pixel clocks,
// with ratio changes deferred to the period boundary.
module crt_clk_en_gen
  import crt_clk_pkg::*;
#(
  parameter int unsigned CNT_W          = 3,
  parameter int unsigned RATIO_8BPP_M1  = 3,
  parameter int unsigned RATIO_16BPP_M1 = 1
) (
  input  logic             pll_clock,
  input  logic             reset_n,
  input  logic             vga_mode,
  input  logic [1:0]       bpp,
  input  logic             div_ovr_en,
  input  logic [CNT_W-1:0] div_ovr_m1,
  input  logic             crt_en,
  input  logic             crt_sync,
  output logic             crt_clk,
  output logic [CNT_W-1:0] crt_phase,
  output logic [CNT_W-1:0] div_cur_m1,
  output logic             div_pending,
  output logic             div_switched
);

  logic [CNT_W-1:0] req_m1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_m1_q, cur_m1_d;
  logic             crt_clk_q, crt_clk_d;
  logic             div_switched_q, div_switched_d;

  crt_div_decode #(
    .CNT_W          (CNT_W),
    .RATIO_8BPP_M1  (RATIO_8BPP_M1),
    .RATIO_16BPP_M1 (RATIO_16BPP_M1)
  ) u_decode (
    .vga_mode   (vga_mode),
    .bpp        (bpp),
    .div_ovr_en (div_ovr_en),
    .div_ovr_m1 (div_ovr_m1),
    .req_m1     (req_m1)
  );

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    cur_m1_d  = cur_m1_q;
    crt_clk_d = 1'b0;
    if (!crt_en) begin
      // Park at the wrap value so the first enabled edge emits a pulse.
      cnt_d    = req_m1;
      cur_m1_d = req_m1;
    end else if (crt_sync || (cnt_q == cur_m1_q)) begin
      cnt_d     = '0;
      crt_clk_d = 1'b1;
      cur_m1_d  = req_m1;
    end
    div_switched_d = (cur_m1_d != cur_m1_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      cur_m1_q       <= '0;
      crt_clk_q      <= 1'b0;
      div_switched_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      cur_m1_q       <= cur_m1_d;
      crt_clk_q      <= crt_clk_d;
      div_switched_q <= div_switched_d;
    end
  end

  assign crt_clk      = crt_clk_q;
  assign crt_phase    = cnt_q;
  assign div_cur_m1   = cur_m1_q;
  assign div_pending  = (req_m1 != cur_m1_q);
  assign div_switched = div_switched_q;

endmodule

// File: tb/tb_crt_clk_en_gen.sv
// Scoreboard bench for crt_clk_en_gen: expected outputs are queued per edge and
// compared one time unit after that edge.
module tb_crt_clk_en_gen;

  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic             clk;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] cur;
    logic             pend;
    logic             sw;
  } exp_t;

  logic             pll_clock;
  logic             reset_n;
  logic             vga_mode;
  logic [1:0]       bpp;
  logic             div_ovr_en;
  logic [CNT_W-1:0] div_ovr_m1;
  logic             crt_en;
  logic             crt_sync;
  logic             crt_clk;
  logic [CNT_W-1:0] crt_phase;
  logic [CNT_W-1:0] div_cur_m1;
  logic             div_pending;
  logic             div_switched;

  exp_t sb_q[$];
  int   checks;
  int   failures;

  crt_clk_en_gen #(
    .CNT_W          (CNT_W),
    .RATIO_8BPP_M1  (3),
    .RATIO_16BPP_M1 (1)
  ) dut (
    .pll_clock    (pll_clock),
    .reset_n      (reset_n),
    .vga_mode     (vga_mode),
    .bpp          (bpp),
    .div_ovr_en   (div_ovr_en),
    .div_ovr_m1   (div_ovr_m1),
    .crt_en       (crt_en),
    .crt_sync     (crt_sync),
    .crt_clk      (crt_clk),
    .crt_phase    (crt_phase),
    .div_cur_m1   (div_cur_m1),
    .div_pending  (div_pending),
    .div_switched (div_switched)
  );

  initial pll_clock = 1'b0;
  always #5 pll_clock = ~pll_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic vga, input logic [1:0] b);
    reset_n    = 1'b0;
    vga_mode   = vga;
    bpp        = b;
    div_ovr_en = 1'b0;
    div_ovr_m1 = '0;
    crt_en     = 1'b1;
    crt_sync   = 1'b0;
    @(negedge pll_clock);
    @(negedge pll_clock);
    reset_n = 1'b1;
  endtask

  task automatic push(input logic c, input int ph, input int cu, input logic pe, input logic s);
    exp_t e;
    e.clk   = c;
    e.phase = CNT_W'(ph);
    e.cur   = CNT_W'(cu);
    e.pend  = pe;
    e.sw    = s;
    sb_q.push_back(e);
  endtask

  // One edge: wait for it, then pop the oldest expectation and compare.
  task automatic step(input string name);
    exp_t e;
    @(posedge pll_clock);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty at time %0t", name, $time);
    end else begin
      e = sb_q.pop_front();
      if (crt_clk !== e.clk) begin
        failures++;
        $display("FAIL %s: crt_clk got %0b exp %0b at %0t", name, crt_clk, e.clk, $time);
      end
      checks++;
      if (crt_phase !== e.phase) begin
        failures++;
        $display("FAIL %s: crt_phase got %0d exp %0d at %0t", name, crt_phase, e.phase, $time);
      end
      checks++;
      if (div_cur_m1 !== e.cur) begin
        failures++;
        $display("FAIL %s: div_cur_m1 got %0d exp %0d at %0t", name, div_cur_m1, e.cur, $time);
      end
      checks++;
      if (div_pending !== e.pend) begin
        failures++;
        $display("FAIL %s: div_pending got %0b exp %0b at %0t", name, div_pending, e.pend, $time);
      end
      checks++;
      if (div_switched !== e.sw) begin
        failures++;
        $display("FAIL %s: div_switched got %0b exp %0b at %0t", name, div_switched, e.sw, $time);
      end
    end
  endtask

  // Steady run at ratio m+1: phase counts modulo m+1, pulse on phase 0.
  task automatic run(input string name, input int n, input int ph0, input int m,
                     input logic pe, input logic sw_first);
    for (int i = 0; i < n; i++) begin
      int ph;
      ph = (ph0 + i) % (m + 1);
      push(ph == 0, ph, m, pe, sw_first && (i == 0));
      step(name);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0, 2'b00);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({crt_clk, crt_phase, div_cur_m1, div_switched} !== '0) begin
      failures++;
      $display("FAIL reset: outputs got %0b/%0d/%0d/%0b exp all zero",
               crt_clk, crt_phase, div_cur_m1, div_switched);
    end
    checks++;
    if (div_pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_pending: got %0b exp 0", div_pending);
    end
    @(negedge pll_clock);
    reset_n = 1'b1;
  endtask

  task automatic test_vga();
    do_reset(1'b1, 2'b01);
    run("vga", 6, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_div4();
    do_reset(1'b0, 2'b01);
    run("div4", 9, 0, 3, 1'b0, 1'b1);
  endtask

  task automatic test_ratio_change();
    do_reset(1'b0, 2'b01);
    run("chg_pre", 6, 0, 3, 1'b0, 1'b1);
    bpp = 2'b10;
    run("chg_wait", 2, 2, 3, 1'b1, 1'b0);
    run("chg_post", 5, 0, 1, 1'b0, 1'b1);
  endtask

  task automatic test_override();
    do_reset(1'b0, 2'b01);
    div_ovr_en = 1'b1;
    div_ovr_m1 = 3'd7;
    run("ovr8", 17, 0, 7, 1'b0, 1'b1);
    div_ovr_m1 = 3'd4;
    run("ovr_wait", 7, 1, 7, 1'b1, 1'b0);
    run("ovr5", 11, 0, 4, 1'b0, 1'b1);
  endtask

  task automatic test_sync();
    do_reset(1'b0, 2'b01);
    run("sync_pre", 3, 0, 3, 1'b0, 1'b1);
    crt_sync = 1'b1;
    push(1'b1, 0, 3, 1'b0, 1'b0);
    step("sync_edge");
    crt_sync = 1'b0;
    run("sync_post", 8, 1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    do_reset(1'b0, 2'b01);
    run("hold_pre", 6, 0, 3, 1'b0, 1'b1);
    crt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 3, 3, 1'b0, 1'b0);
      step("hold8");
    end
    bpp = 2'b10;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 1, 1, 1'b0, i == 0);
      step("hold16");
    end
    crt_en = 1'b1;
    run("hold_resume", 5, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 2'b01);
    run("rst_pre", 3, 0, 3, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({crt_clk, crt_phase, div_cur_m1, div_switched} !== '0) begin
      failures++;
      $display("FAIL reset_mid: outputs got %0b/%0d/%0d/%0b exp all zero",
               crt_clk, crt_phase, div_cur_m1, div_switched);
    end
    checks++;
    if (div_pending !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pending: got %0b exp 1", div_pending);
    end
    @(negedge pll_clock);
    reset_n = 1'b1;
    run("rst_post", 4, 0, 3, 1'b0, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_vga();
    test_div4();
    test_ratio_change();
    test_override();
    test_sync();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
